// File: rtl/text_pkg.sv
// Shared constants, FSM encodings and the text-cell address helper for the text-mode buffer controller.
// Pure definitions: no latency, no flow control.
package text_pkg;
    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int CHAR_W = 7;
    localparam int ADDR_W = 12;
    localparam int CELLS  = COLS * ROWS;

    localparam logic [CHAR_W-1:0] BLANK_CHAR = 7'h00;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t WRITE = 2'd1;
    localparam state_t ACK   = 2'd2;
    localparam state_t CLEAR = 2'd3;

    // row*80 + col as shift-add: 80 = 64 + 16
    function automatic logic [ADDR_W-1:0] addr_of(input logic [4:0] row, input logic [6:0] col);
        logic [ADDR_W-1:0] r;
        r = ADDR_W'(row);
        return (r << 6) + (r << 4) + ADDR_W'(col);
    endfunction
endpackage

// File: rtl/text_fetch_pipe.sv
// Display fetch pipeline: pixel position -> char-RAM address -> font-ROM address -> font bit.
// Latency 3 clk from pixel_tick to font_bit/video_on_d; no backpressure, display always wins the RAM.
module text_fetch_pipe
    import text_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              pixel_tick_i,
    input  logic              video_on_i,
    input  logic [9:0]        pixel_x_i,
    input  logic [9:0]        pixel_y_i,
    input  logic [CHAR_W-1:0] ram_rdata_i,
    input  logic [7:0]        font_word_i,
    output logic              disp_slot_o,
    output logic [ADDR_W-1:0] disp_addr_o,
    output logic [10:0]       rom_addr_o,
    output logic              font_bit_o,
    output logic              video_on_d_o
);
    logic       s1_vld_q, s1_vid_q;
    logic [3:0] s1_row_q;
    logic [2:0] s1_bit_q;
    logic       s2_vld_q, s2_vid_q;
    logic [2:0] s2_bit_q;
    logic       font_bit_q, video_on_d_q;
    logic       unused_y;

    assign unused_y     = pixel_y_i[9];
    assign disp_slot_o  = pixel_tick_i & video_on_i;
    assign disp_addr_o  = disp_slot_o ? addr_of(pixel_y_i[8:4], pixel_x_i[9:3]) : '0;
    assign rom_addr_o   = s1_vid_q ? {ram_rdata_i, s1_row_q} : '0;
    assign font_bit_o   = font_bit_q;
    assign video_on_d_o = video_on_d_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_vld_q     <= 1'b0;
            s1_vid_q     <= 1'b0;
            s1_row_q     <= '0;
            s1_bit_q     <= '0;
            s2_vld_q     <= 1'b0;
            s2_vid_q     <= 1'b0;
            s2_bit_q     <= '0;
            font_bit_q   <= 1'b0;
            video_on_d_q <= 1'b0;
        end else begin
            s1_vld_q <= pixel_tick_i;
            s1_vid_q <= disp_slot_o;
            if (pixel_tick_i) begin
                s1_row_q <= pixel_y_i[3:0];
                s1_bit_q <= pixel_x_i[2:0];
            end
            s2_vld_q <= s1_vld_q;
            s2_vid_q <= s1_vid_q;
            s2_bit_q <= s1_bit_q;
            // Outputs only move when a tick arrives, so they hold between pixels
            if (s2_vld_q) begin
                video_on_d_q <= s2_vid_q;
                font_bit_q   <= s2_vid_q & font_word_i[~s2_bit_q];
            end
        end
    end
endmodule

// File: rtl/text_buffer_ctrl.sv
// Text-mode controller: display fetch pipeline plus host write/clear arbiter on the single-port char RAM.
// Display latency 3 clk; host writes and clear steps only use cycles that are not display slots.
module text_buffer_ctrl
    import text_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              pixel_tick,
    input  logic              video_on,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [CHAR_W-1:0] ram_wdata,
    input  logic [CHAR_W-1:0] ram_rdata,
    output logic [10:0]       rom_addr,
    input  logic [7:0]        font_word,
    output logic              font_bit,
    output logic              video_on_d,
    input  logic              wr_req,
    input  logic [6:0]        wr_col,
    input  logic [4:0]        wr_row,
    input  logic [CHAR_W-1:0] wr_char,
    output logic              wr_ack,
    output logic              wr_err,
    input  logic              clr_req,
    output logic              clr_busy
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [CHAR_W-1:0] wchar_q, wchar_d;
    logic              err_q, err_d;
    logic              disp_slot;
    logic [ADDR_W-1:0] disp_addr;

    text_fetch_pipe u_pipe (
        .clk          (clk),
        .reset        (reset),
        .pixel_tick_i (pixel_tick),
        .video_on_i   (video_on),
        .pixel_x_i    (pixel_x),
        .pixel_y_i    (pixel_y),
        .ram_rdata_i  (ram_rdata),
        .font_word_i  (font_word),
        .disp_slot_o  (disp_slot),
        .disp_addr_o  (disp_addr),
        .rom_addr_o   (rom_addr),
        .font_bit_o   (font_bit),
        .video_on_d_o (video_on_d)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        waddr_d   = waddr_q;
        wchar_d   = wchar_q;
        err_d     = err_q;
        ram_we    = 1'b0;
        ram_addr  = disp_addr;
        ram_wdata = '0;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                end else if (wr_req) begin
                    if (wr_col < 7'(COLS) && wr_row < 5'(ROWS)) begin
                        state_d = WRITE;
                        waddr_d = addr_of(wr_row, wr_col);
                        wchar_d = wr_char;
                        err_d   = 1'b0;
                    end else begin
                        state_d = ACK;
                        err_d   = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (!disp_slot) begin
                    ram_we    = 1'b1;
                    ram_addr  = waddr_q;
                    ram_wdata = wchar_q;
                    state_d   = ACK;
                end
            end
            ACK: state_d = IDLE;
            CLEAR: begin
                if (!disp_slot) begin
                    ram_we    = 1'b1;
                    ram_addr  = cnt_q;
                    ram_wdata = BLANK_CHAR;
                    if (cnt_q == ADDR_W'(CELLS - 1)) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_ack   = (state_q == ACK);
    assign wr_err   = (state_q == ACK) & err_q;
    assign clr_busy = (state_q == CLEAR);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            waddr_q <= '0;
            wchar_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            wchar_q <= wchar_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: doc/text_buffer_ctrl.md
Name: text_buffer_ctrl

Overview:
- Sequences the text-mode pixel datapath: converts pixel_x/pixel_y into character-buffer reads, then font-ROM reads, and delivers one pipelined font_bit per pixel, aligned with a delayed video_on.
- Arbitrates the single-port character RAM between display fetches (priority) and a host writer (single-character writes plus a full-screen clear).
- Sits between the VGA sync generator and the colour stage; the RAM and font ROM stay external.

Parameters:
- COLS, 80, characters per text row (pixel_x[9:3]).
- ROWS, 30, text rows (pixel_y[8:4]).
- CHAR_W, 7, character code width.
- ADDR_W, 12, char-RAM address width (COLS*ROWS ≤ 2^ADDR_W).
- BLANK_CHAR, 7'h00, code written by clear.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- pixel_tick  in  1  one-clk pixel enable from sync generator
- video_on  in  1  visible-area flag, valid with pixel_x/pixel_y
- pixel_x  in  10  current pixel column
- pixel_y  in  10  current pixel row
- ram_addr  out  ADDR_W  char-RAM address
- ram_we  out  1  char-RAM write enable
- ram_wdata  out  CHAR_W  char-RAM write data
- ram_rdata  in  CHAR_W  char-RAM read data, 1-clk synchronous read
- rom_addr  out  11  font-ROM address {code, row[3:0]}
- font_word  in  8  font-ROM data, 1-clk synchronous read
- font_bit  out  1  pixel bit, aligned with video_on_d
- video_on_d  out  1  video_on delayed to match font_bit
- wr_req  in  1  host write request; level, held until wr_ack
- wr_col  in  7  target column
- wr_row  in  5  target row
- wr_char  in  CHAR_W  character code
- wr_ack  out  1  one-clk pulse: request consumed
- wr_err  out  1  valid with wr_ack: coordinates out of range, nothing written
- clr_req  in  1  one-clk pulse: clear the whole buffer
- clr_busy  out  1  high while a clear is in progress

Behaviour:
- Reset (reset==0 at a clk edge): every output is 0. FSM goes to IDLE, clear counter is 0, pipeline valid bits are 0.
- Display slot: a cycle with pixel_tick=1 and video_on=1.
  - ram_addr = pixel_y[8:4]*COLS + pixel_x[9:3], computed as (r<<6)+(r<<4)+c for COLS=80, width ADDR_W; ram_we=0.
  - Stage 1: the registered copy of pixel_y[3:0] forms rom_addr = {ram_rdata, row}.
  - Stage 2: font_bit and video_on_d register font_word[~bit_d2], using pixel_x[2:0] delayed 2 clk.
  - Latency: tick at cycle T gives font_bit/video_on_d updated at T+3. Both hold until the next tick propagates.
  - A tick with video_on=0 propagates video_on_d=0, font_bit=0, with no RAM access.
- Free slot: any cycle that is not a display slot. Only free slots may drive ram_we=1, and only one write per free slot.
- FSM states:
  - IDLE:
    - clr_req → CLEAR; clr_req wins over a simultaneous wr_req.
    - wr_req with wr_col<COLS and wr_row<ROWS → WRITE.
    - wr_req out of range → ACK with wr_err=1.
  - WRITE: waits for a free slot. Drives ram_addr=wr_row*COLS+wr_col, ram_wdata=wr_char, ram_we=1 for one clk, then → ACK.
  - ACK: wr_ack=1 for one clk (wr_err as decided), then → IDLE. Host must drop or change wr_req in the cycle after wr_ack. wr_req still high in IDLE is a new request.
  - CLEAR: clr_busy=1. On each free slot, writes BLANK_CHAR to address cnt, then cnt++. After writing COLS*ROWS-1 (2399), cnt returns to 0 and the FSM → IDLE; clr_busy drops the following clk. wr_req is not acked during CLEAR. clr_req during CLEAR is ignored (no restart).
- Display reads always win; a write never delays or corrupts the display pipeline.
- During the blanking interval every cycle is free: a full clear takes exactly 2400 clk when video_on stays 0.
- Reset mid-CLEAR or mid-WRITE aborts the operation immediately. ram_we=0 from that edge; no ack is issued.
- pixel_x ≥ 640 or pixel_y ≥ 480 only occur with video_on=0 and need no address checking.

Decomposition:
- Shared package text_pkg: COLS, ROWS, CHAR_W, ADDR_W, BLANK_CHAR, FSM state enum (IDLE, WRITE, ACK, CLEAR), and an addr_of(row,col) function used by both the display and write paths.
- One natural sub-module, text_fetch_pipe: the 3-stage display pipeline (address, ROM address, bit select, video_on alignment). The arbiter/FSM stays in text_buffer_ctrl.

Test Plan:
- Reset with wr_req=1, clr_req=1 held, reset=0 for 3 clk → all outputs 0; no ram_we for the whole reset.
- Preload RAM[1*80+2]=7'h41, ROM row 5 of 0x41 = 8'b1000_0001; tick with pixel_x=16, pixel_y=21, video_on=1 → ram_addr=82 at T, rom_addr=11'h415 at T+1, font_bit=1 and video_on_d=1 at T+3. With pixel_x=17 → font_bit=0.
- Ticks every 4 clk with video_on=1; wr_req (col 5, row 3, char 7'h33) → ram_we=1 only on a non-tick cycle with ram_addr=245, ram_wdata=7'h33; wr_ack pulse 1 clk later with wr_err=0; display stream unchanged.
- wr_req with col 80, row 0 → wr_ack=1, wr_err=1, no ram_we.
- clr_req with video_on=0 throughout → 2400 consecutive writes of 7'h00 at addresses 0..2399; clr_busy high for 2400 clk; a wr_req raised during the clear is acked only after clr_busy falls.
- clr_req and wr_req asserted in the same cycle → CLEAR runs first; reset asserted mid-clear (cnt≈1000) → ram_we=0 and clr_busy=0 next edge; after reset release the FSM is in IDLE.
